// File: rtl/alloc_list_ctrl.sv
// First-fit block allocator over an address-ordered, doubly linked node table.
// One node is examined per cycle; a released block coalesces with both neighbours.
module alloc_list_ctrl #(
    parameter int ADDR_W = 12,
    parameter int NODES  = 64,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_req,
    input  logic [LEN_W-1:0]  alloc_len,
    input  logic              free_req,
    input  logic [ADDR_W-1:0] free_addr,
    output logic              ready,
    output logic              done,
    output logic              ok,
    output logic [ADDR_W-1:0] alloc_addr,
    output logic [ADDR_W:0]   free_units
);
    localparam int SW = $clog2(NODES);
    localparam int IW = $clog2(NODES + 1);
    localparam logic [IW-1:0] NIL = '1;
    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        IDLE, A_SCAN, A_COMMIT, F_SCAN, F_MERGE_N, F_MERGE_P, RESP
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] nstart [NODES];
    logic [ADDR_W:0]   nsize  [NODES];
    logic [IW-1:0]     nprev  [NODES];
    logic [IW-1:0]     nnext  [NODES];
    logic [NODES-1:0]  nused, nvalid;
    logic [IW-1:0]     head, cur;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] faddr, addr_q;
    logic [ADDR_W:0]   units;
    logic              ok_q, fit, hit;

    logic [SW-1:0]     cs, ns, ps, slot;
    logic [IW-1:0]     c_next, c_prev, nn;
    logic [ADDR_W:0]   len_x, c_size;
    logic              c_fits, c_exact, c_match;
    logic              n_free, p_free, slot_ok;

    // Pointers are one bit wider than slot indices so all-ones never aliases a slot.
    assign cs      = cur[SW-1:0];
    assign c_size  = nsize[cs];
    assign c_next  = nnext[cs];
    assign c_prev  = nprev[cs];
    assign ns      = c_next[SW-1:0];
    assign ps      = c_prev[SW-1:0];
    assign nn      = nnext[ns];
    assign len_x   = (ADDR_W+1)'(len);
    assign c_fits  = !nused[cs] && (c_size >= len_x);
    assign c_exact = (c_size == len_x);
    assign c_match = nused[cs] && (nstart[cs] == faddr);
    assign n_free  = (c_next != NIL) && !nused[ns];
    assign p_free  = (c_prev != NIL) && !nused[ps];

    always_comb begin
        slot    = '0;
        slot_ok = 1'b0;
        for (int i = NODES - 1; i >= 0; i--) begin
            if (!nvalid[i]) begin
                slot    = SW'(i);
                slot_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (free_req)       state_nx = F_SCAN;
                else if (alloc_req) state_nx = A_SCAN;
            end
            A_SCAN: begin
                if (len == '0)                     state_nx = RESP;
                else if (c_fits || c_next == NIL)  state_nx = A_COMMIT;
            end
            A_COMMIT: state_nx = RESP;
            F_SCAN: begin
                if (hit)                            state_nx = F_MERGE_N;
                else if (!c_match && c_next == NIL) state_nx = RESP;
            end
            F_MERGE_N: state_nx = F_MERGE_P;
            F_MERGE_P: state_nx = RESP;
            RESP:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
        done  = (state == RESP);
        ok    = (state == RESP) && ok_q;
    end

    assign alloc_addr = addr_q;
    assign free_units = units;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NODES; i++) begin
                nstart[i] <= '0;
                nsize[i]  <= '0;
                nprev[i]  <= NIL;
                nnext[i]  <= NIL;
            end
            nsize[0] <= FULL;
            nused    <= '0;
            nvalid   <= NODES'(1);
            head     <= '0;
            cur      <= '0;
            len      <= '0;
            faddr    <= '0;
            addr_q   <= '0;
            units    <= FULL;
            ok_q     <= 1'b0;
            fit      <= 1'b0;
            hit      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    cur   <= head;
                    len   <= alloc_len;
                    faddr <= free_addr;
                    ok_q  <= 1'b0;
                    fit   <= 1'b0;
                    hit   <= 1'b0;
                end
                A_SCAN: begin
                    if (len != '0 && !c_fits && c_next != NIL) cur <= c_next;
                    else                                       fit <= c_fits;
                end
                A_COMMIT: begin
                    if (fit && c_exact) begin
                        nused[cs] <= 1'b1;
                        ok_q      <= 1'b1;
                        addr_q    <= nstart[cs];
                        units     <= units - len_x;
                    end else if (fit && slot_ok) begin
                        // New used node takes the low part; old node keeps the tail.
                        nvalid[slot] <= 1'b1;
                        nused[slot]  <= 1'b1;
                        nstart[slot] <= nstart[cs];
                        nsize[slot]  <= len_x;
                        nprev[slot]  <= c_prev;
                        nnext[slot]  <= cur;
                        if (c_prev == NIL) head      <= IW'(slot);
                        else               nnext[ps] <= IW'(slot);
                        nprev[cs]  <= IW'(slot);
                        nstart[cs] <= nstart[cs] + ADDR_W'(len);
                        nsize[cs]  <= c_size - len_x;
                        ok_q       <= 1'b1;
                        addr_q     <= nstart[cs];
                        units      <= units - len_x;
                    end
                end
                F_SCAN: begin
                    if (hit) begin
                        nused[cs] <= 1'b0;
                        units     <= units + c_size;
                    end else if (c_match) begin
                        hit <= 1'b1;
                    end else if (c_next != NIL) begin
                        cur <= c_next;
                    end
                end
                F_MERGE_N: begin
                    if (n_free) begin
                        nsize[cs]  <= c_size + nsize[ns];
                        nnext[cs]  <= nn;
                        nvalid[ns] <= 1'b0;
                        if (nn != NIL) nprev[nn[SW-1:0]] <= cur;
                    end
                end
                F_MERGE_P: begin
                    ok_q <= 1'b1;
                    if (p_free) begin
                        nsize[ps]  <= nsize[ps] + c_size;
                        nnext[ps]  <= c_next;
                        nvalid[cs] <= 1'b0;
                        if (c_next != NIL) nprev[ns] <= c_prev;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alloc_list_ctrl.sv
// Scoreboard bench for alloc_list_ctrl: directed ops push expected
// responses, a negedge monitor pops and compares on every done pulse.
module tb_alloc_list_ctrl;
    localparam int AW = 12;
    localparam int LW = 8;

    typedef struct {
        logic          ok;
        logic          chk_addr;
        logic [AW-1:0] addr;
        logic [AW:0]   fu;
        int            lat;
        int            t0;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    areq, freq, rdy, dn, okv;
    logic [AW-1:0] fa [2];
    logic [AW-1:0] aa [2];
    logic [LW-1:0] al [2];
    logic [AW:0]   fu [2];

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alloc_list_ctrl #(.ADDR_W(AW), .NODES(64), .LEN_W(LW)) dut0 (
        .clk(clk), .rst(rst),
        .alloc_req(areq[0]), .alloc_len(al[0]),
        .free_req(freq[0]), .free_addr(fa[0]),
        .ready(rdy[0]), .done(dn[0]), .ok(okv[0]),
        .alloc_addr(aa[0]), .free_units(fu[0])
    );

    alloc_list_ctrl #(.ADDR_W(AW), .NODES(4), .LEN_W(LW)) dut1 (
        .clk(clk), .rst(rst),
        .alloc_req(areq[1]), .alloc_len(al[1]),
        .free_req(freq[1]), .free_addr(fa[1]),
        .ready(rdy[1]), .done(dn[1]), .ok(okv[1]),
        .alloc_addr(aa[1]), .free_units(fu[1])
    );

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic exp_t ex(input logic o, input logic ca, input int a,
                                input int f, input int l);
        exp_t e;
        e.ok       = o;
        e.chk_addr = ca;
        e.addr     = AW'(a);
        e.fu       = (AW+1)'(f);
        e.lat      = l;
        e.t0       = 0;
        return e;
    endfunction

    task automatic pop_check(input int d);
        exp_t e;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done dut%0d: got done=1, expected none", d);
            return;
        end
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        cmp($sformatf("dut%0d_ok", d), 32'(okv[d]), 32'(e.ok));
        if (e.chk_addr) cmp($sformatf("dut%0d_addr", d), 32'(aa[d]), 32'(e.addr));
        cmp($sformatf("dut%0d_free_units", d), 32'(fu[d]), 32'(e.fu));
        if (e.lat >= 0) cmp($sformatf("dut%0d_latency", d), 32'(cyc - e.t0 + 1), 32'(e.lat));
    endtask

    always @(negedge clk) begin
        if (dn[0] === 1'b1) pop_check(0);
        if (dn[1] === 1'b1) pop_check(1);
    end

    task automatic issue(input int d, input logic fr, input logic ar,
                         input int a, input int l, input exp_t e);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rdy[d] !== 1'b1 && n < 500);
        if (rdy[d] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout dut%0d: got ready=%b, expected 1", d, rdy[d]);
            return;
        end
        freq[d] = fr;
        areq[d] = ar;
        fa[d]   = AW'(a);
        al[d]   = LW'(l);
        e.t0    = cyc + 1;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        @(posedge clk);
        #1;
        freq[d] = 1'b0;
        areq[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(rdy[d] === 1'b1 && (d == 0 ? q0.size() : q1.size()) == 0) && n < 1000);
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout dut%0d: got pending=%0d, expected 0", d,
                     d == 0 ? q0.size() : q1.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of run, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        areq = '0;
        freq = '0;
        for (int i = 0; i < 2; i++) begin
            fa[i] = '0;
            al[i] = '0;
        end
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        cmp("rst_ready", 32'(rdy[0]), 1);
        cmp("rst_done", 32'(dn[0]), 0);
        cmp("rst_ok", 32'(okv[0]), 0);
        cmp("rst_addr", 32'(aa[0]), 0);
        cmp("rst_free_units", 32'(fu[0]), 4096);
        rst = 1'b1;

        issue(0, 0, 1, 0, 16, ex(1, 1, 0, 4080, 3));
        issue(0, 0, 1, 0, 32, ex(1, 1, 16, 4048, 4));
        issue(0, 0, 1, 0, 8, ex(1, 1, 48, 4040, 5));
        issue(0, 1, 0, 16, 0, ex(1, 0, 0, 4072, 6));
        issue(0, 0, 1, 0, 32, ex(1, 1, 16, 4040, 4));
        drain(0);
        cmp("reuse_node_count", 32'($countones(dut0.nvalid)), 4);

        issue(0, 1, 0, 5, 0, ex(0, 0, 0, 4040, -1));
        issue(0, 1, 0, 0, 0, ex(1, 0, 0, 4056, 5));
        issue(0, 1, 0, 0, 0, ex(0, 0, 0, 4056, -1));
        issue(0, 1, 0, 48, 0, ex(1, 0, 0, 4064, 7));
        issue(0, 1, 0, 16, 0, ex(1, 0, 0, 4096, 6));
        drain(0);
        cmp("coalesce_node_count", 32'($countones(dut0.nvalid)), 1);
        cmp("coalesce_start", 32'(dut0.nstart[dut0.head[5:0]]), 0);
        cmp("coalesce_size", 32'(dut0.nsize[dut0.head[5:0]]), 4096);
        cmp("coalesce_used", 32'(dut0.nused[dut0.head[5:0]]), 0);

        issue(1, 0, 1, 0, 1, ex(1, 1, 0, 4095, 3));
        issue(1, 0, 1, 0, 1, ex(1, 1, 1, 4094, 4));
        issue(1, 0, 1, 0, 1, ex(1, 1, 2, 4093, 5));
        issue(1, 0, 1, 0, 1, ex(0, 0, 0, 4093, 6));
        issue(1, 0, 1, 0, 0, ex(0, 0, 0, 4093, 2));
        drain(1);

        issue(0, 0, 1, 0, 4, ex(1, 1, 0, 4092, 3));
        issue(0, 1, 1, 0, 4, ex(1, 0, 0, 4096, 5));
        drain(0);

        issue(0, 0, 1, 0, 16, ex(1, 1, 0, 4080, 3));
        issue(0, 0, 1, 0, 16, ex(1, 1, 16, 4064, 4));
        drain(0);
        @(negedge clk);
        areq[0] = 1'b1;
        al[0]   = 8'd200;
        @(posedge clk);
        #1 areq[0] = 1'b0;
        @(negedge clk);
        cmp("scan_busy", 32'(rdy[0]), 0);
        rst = 1'b0;
        #1;
        cmp("midrst_ready", 32'(rdy[0]), 1);
        cmp("midrst_done", 32'(dn[0]), 0);
        cmp("midrst_ok", 32'(okv[0]), 0);
        cmp("midrst_addr", 32'(aa[0]), 0);
        cmp("midrst_free_units", 32'(fu[0]), 4096);
        cmp("midrst_free_units_dut1", 32'(fu[1]), 4096);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        issue(0, 0, 1, 0, 16, ex(1, 1, 0, 4080, 3));
        drain(0);
        drain(1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
